// File: rtl/tcdm_mem_model_if.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_mem_model_if
// Purpose  : Multi-port PULP req/gnt/r_valid bus bundle for tcdm_mem_model.
// Revision : 1.0 - initial release
// ============================================================================
interface tcdm_mem_model_if #(
  parameter int MP = 2
);
  logic [MP-1:0]       req;
  logic [MP-1:0]       wen;
  logic [MP-1:0][31:0] add;
  logic [MP-1:0][3:0]  be;
  logic [MP-1:0][31:0] data;
  logic [MP-1:0]       gnt;
  logic [MP-1:0]       r_valid;
  logic [MP-1:0][31:0] r_data;

  modport master (
    output req, wen, add, be, data,
    input  gnt, r_valid, r_data
  );

  modport slave (
    input  req, wen, add, be, data,
    output gnt, r_valid, r_data
  );
endinterface
`default_nettype wire

// File: rtl/tcdm_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_mem_model
// Purpose  : Multi-port word-addressed TCDM/L2 bank model with optional grant
//            stalls (compiled in by defining TCDM_MODEL_STALL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tcdm_mem_model #(
  parameter int          MP           = 2,
  parameter int          MEM_WORDS    = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [7:0]  STALL_THRESH = 8'd128
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  input  wire logic         enable_i,
  input  wire logic         stallable_i,
  input  wire logic         randomize_i,
  tcdm_mem_model_if.slave   bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0]          mem [MEM_WORDS];
  logic [MP-1:0][IDX_W-1:0] idx;
  logic [MP-1:0]        stall;
  logic [MP-1:0]        hs;
  logic [MP-1:0]        rvalid_q;
  logic [MP-1:0][31:0]  rdata_q;

  for (genvar p = 0; p < MP; p++) begin : g_port
    logic [31:0] byte_off;
    logic        unused_off;

    // Offset wraps modulo the array depth; the byte lane bits are dropped.
    assign byte_off   = bus.add[p] - BASE_ADDR;
    assign idx[p]     = byte_off[IDX_W+1:2];
    assign unused_off = ^{byte_off[31:IDX_W+2], byte_off[1:0]};

    assign bus.gnt[p] = bus.req[p] & enable_i & ~stall[p];
    assign hs[p]      = bus.req[p] & bus.gnt[p];
  end

`ifdef TCDM_MODEL_STALL_EN
  for (genvar p = 0; p < MP; p++) begin : g_stall
    logic [15:0] lfsr;
    logic [1:0]  phase;
    logic        fb;

    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        lfsr  <= 16'hACE1 ^ 16'(p);
        phase <= 2'd0;
      end else begin
        lfsr  <= {lfsr[14:0], fb};
        phase <= phase + 2'd1;
      end
    end

    always_comb begin
      stall[p] = 1'b0;
      if (stallable_i) begin
        if (randomize_i) stall[p] = (lfsr[7:0] < STALL_THRESH);
        else             stall[p] = (phase < STALL_THRESH[7:6]);
      end
    end
  end
`else
  logic unused_stall_cfg;

  assign stall            = '0;
  assign unused_stall_cfg = ^{stallable_i, randomize_i, STALL_THRESH};
`endif

  // Ascending port order makes the highest-index writer win per byte.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < MP; p++) begin
      if (hs[p] && !bus.wen[p]) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.be[p][b]) mem[idx[p]][b*8 +: 8] <= bus.data[p][b*8 +: 8];
        end
      end
    end
  end

  // Reads sample the pre-edge array, so a same-cycle write is not visible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      for (int p = 0; p < MP; p++) begin
        rvalid_q[p] <= hs[p];
        if (hs[p] && bus.wen[p]) rdata_q[p] <= mem[idx[p]];
      end
    end
  end

  assign bus.r_valid = rvalid_q;
  assign bus.r_data  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_tcdm_mem_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcdm_mem_model
// Purpose  : Table-driven self-checking bench for tcdm_mem_model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcdm_mem_model;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable, stallable, randomize;

  always #5 clk = ~clk;

  tcdm_mem_model_if #(.MP(2)) bus ();

  tcdm_mem_model #(
    .MP(2), .MEM_WORDS(4096), .BASE_ADDR(32'h0000_0000), .STALL_THRESH(8'd128)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (enable),
    .stallable_i(stallable),
    .randomize_i(randomize),
    .bus        (bus.slave)
  );

  typedef struct {
    string       name;
    logic        en;
    logic [1:0]  req;
    logic [1:0]  wen;
    logic [31:0] a0, a1;
    logic [3:0]  be0, be1;
    logic [31:0] d0, d1;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    logic [1:0]  chk_rd;
    logic [31:0] exp_r0, exp_r1;
  } vec_t;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mkv(input string n, input logic en, input logic [1:0] req,
                               input logic [1:0] wen, input logic [31:0] a0, input logic [31:0] a1,
                               input logic [3:0] be0, input logic [3:0] be1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [1:0] eg, input logic [1:0] erv, input logic [1:0] chk,
                               input logic [31:0] r0, input logic [31:0] r1);
    vec_t v;
    v.name = n; v.en = en; v.req = req; v.wen = wen; v.a0 = a0; v.a1 = a1;
    v.be0 = be0; v.be1 = be1; v.d0 = d0; v.d1 = d1; v.exp_gnt = eg; v.exp_rv = erv;
    v.chk_rd = chk; v.exp_r0 = r0; v.exp_r1 = r1;
    return v;
  endfunction

  task automatic drive(input logic en, input logic [1:0] req, input logic [1:0] wen,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [3:0] be0, input logic [3:0] be1,
                       input logic [31:0] d0, input logic [31:0] d1);
    enable = en; bus.req = req; bus.wen = wen;
    bus.add[0] = a0; bus.add[1] = a1; bus.be[0] = be0; bus.be[1] = be1;
    bus.data[0] = d0; bus.data[1] = d1;
  endtask

  vec_t vecs[18];

  initial begin
    int   cnt;
    logic [7:0] g;
    logic pat_ok;

    vecs[0]  = mkv("wr_full",  1, 2'b01, 2'b10, 32'h10, 0, 4'hF, 0, 32'hDEADBEEF, 0, 2'b01, 2'b01, 2'b00, 0, 0);
    vecs[1]  = mkv("rd_full",  1, 2'b01, 2'b11, 32'h10, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 32'hDEADBEEF, 0);
    vecs[2]  = mkv("wr_part",  1, 2'b01, 2'b10, 32'h10, 0, 4'b0101, 0, 32'h11223344, 0, 2'b01, 2'b01, 2'b01, 32'hDEADBEEF, 0);
    vecs[3]  = mkv("rd_part",  1, 2'b01, 2'b11, 32'h10, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 32'hDE22BE44, 0);
    vecs[4]  = mkv("coll_wr",  1, 2'b11, 2'b00, 32'h20, 32'h20, 4'hF, 4'hF, 32'hAAAAAAAA, 32'h55555555, 2'b11, 2'b11, 2'b11, 32'hDE22BE44, 0);
    vecs[5]  = mkv("coll_rd",  1, 2'b01, 2'b11, 32'h20, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 32'h55555555, 0);
    vecs[6]  = mkv("rw_coll",  1, 2'b11, 2'b01, 32'h20, 32'h20, 0, 4'hF, 0, 32'h12345678, 2'b11, 2'b11, 2'b01, 32'h55555555, 0);
    vecs[7]  = mkv("rd_new",   1, 2'b10, 2'b11, 0, 32'h20, 0, 0, 0, 0, 2'b10, 2'b10, 2'b10, 0, 32'h12345678);
    vecs[8]  = mkv("byte_wr",  1, 2'b11, 2'b00, 32'h30, 32'h30, 4'hF, 4'h3, 32'h11111111, 32'h22222222, 2'b11, 2'b11, 2'b00, 0, 0);
    vecs[9]  = mkv("byte_rd",  1, 2'b10, 2'b11, 0, 32'h30, 0, 0, 0, 0, 2'b10, 2'b10, 2'b10, 0, 32'h11112222);
    vecs[10] = mkv("idle",     1, 2'b00, 2'b11, 32'h10, 32'h10, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 32'h55555555, 32'h11112222);
    vecs[11] = mkv("dis_wr",   0, 2'b01, 2'b10, 32'h10, 0, 4'hF, 0, 32'hFFFFFFFF, 0, 2'b00, 2'b00, 2'b01, 32'h55555555, 0);
    vecs[12] = mkv("dis_rd",   0, 2'b10, 2'b11, 0, 32'h30, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 32'h11112222);
    vecs[13] = mkv("en_rd",    1, 2'b01, 2'b11, 32'h10, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 32'hDE22BE44, 0);
    vecs[14] = mkv("wr_w0",    1, 2'b01, 2'b10, 32'h0, 0, 4'hF, 0, 32'hCAFEF00D, 0, 2'b01, 2'b01, 2'b00, 0, 0);
    vecs[15] = mkv("alias",    1, 2'b10, 2'b11, 0, 32'h0001_0000, 0, 0, 0, 0, 2'b10, 2'b10, 2'b10, 0, 32'hCAFEF00D);
    vecs[16] = mkv("low_bits", 1, 2'b01, 2'b11, 32'h13, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b01, 32'hDE22BE44, 0);
    vecs[17] = mkv("b2b",      1, 2'b11, 2'b11, 32'h0, 32'h20, 0, 0, 0, 0, 2'b11, 2'b11, 2'b11, 32'hCAFEF00D, 32'h12345678);

    stallable = 1'b0; randomize = 1'b0;
    drive(1'b1, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", {30'd0, bus.r_valid}, 32'd0);
    check("rst_rdata0", bus.r_data[0], 32'd0);
    check("rst_rdata1", bus.r_data[1], 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].req, vecs[i].wen, vecs[i].a0, vecs[i].a1,
            vecs[i].be0, vecs[i].be1, vecs[i].d0, vecs[i].d1);
      #1;
      check({vecs[i].name, "_gnt"}, {30'd0, bus.gnt}, {30'd0, vecs[i].exp_gnt});
      @(posedge clk);
      #1;
      check({vecs[i].name, "_rvalid"}, {30'd0, bus.r_valid}, {30'd0, vecs[i].exp_rv});
      if (vecs[i].chk_rd[0]) check({vecs[i].name, "_rdata0"}, bus.r_data[0], vecs[i].exp_r0);
      if (vecs[i].chk_rd[1]) check({vecs[i].name, "_rdata1"}, bus.r_data[1], vecs[i].exp_r1);
    end

    // Reset lands on the edge that would complete a read handshake.
    @(negedge clk);
    drive(1'b1, 2'b01, 2'b11, 32'h10, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_rvalid", {30'd0, bus.r_valid}, 32'd0);
    check("rst_mid_rdata0", bus.r_data[0], 32'd0);
    @(negedge clk);
    drive(1'b1, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    drive(1'b1, 2'b01, 2'b11, 32'h10, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("post_rst_rvalid", {30'd0, bus.r_valid}, 32'd1);
    check("post_rst_rdata0", bus.r_data[0], 32'hDE22BE44);

    // Periodic stall window: port0 read request held for 8 cycles.
    stallable = 1'b1; randomize = 1'b0;
    g = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      g[c] = bus.gnt[0];
    end
    cnt = 0;
    for (int c = 0; c < 8; c++) cnt += int'(g[c]);
    pat_ok = 1'b1;
    for (int c = 0; c < 6; c++) if (g[c] == g[c+2]) pat_ok = 1'b0;
`ifdef TCDM_MODEL_STALL_EN
    check("periodic_count", cnt, 32'd4);
    check("periodic_pattern", {31'd0, pat_ok}, 32'd1);
`else
    check("nostall_count", cnt, 32'd8);
    check("nostall_pattern", {24'd0, g}, 32'h000000FF);
`endif

    randomize = 1'b1;
    cnt = 0;
    for (int c = 0; c < 1024; c++) begin
      @(negedge clk);
      #1;
      cnt += int'(bus.gnt[0]);
    end
`ifdef TCDM_MODEL_STALL_EN
    check("random_ratio_ok", {31'd0, (cnt >= 461 && cnt <= 563)}, 32'd1);
`else
    check("nostall_random", cnt, 32'd1024);
`endif

    @(negedge clk);
    drive(1'b1, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0);
    stallable = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("final_idle_rvalid", {30'd0, bus.r_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
